spi_master_tx: RTL
==================

Name: spi_master_tx

Overview:
- SPI mode-0 initiator (CPOL=0, CPHA=0) that drives the SCLK, MOSI and CS_N pins consumed by the FPGA pin-level receive side, and captures MISO.
- Accepts DATA_W-bit words over a valid/ready handshake, serialises them MSB-first and returns each received word with a one-cycle valid pulse.
- Sits between the on-chip command/spike-packet logic and the physical SPI pins. Supports back-to-back bursts with CS_N held low.

Parameters:
- DATA_W, 8: bits per word; legal ≥2.
- CLK_DIV, 4: SCLK half-period in clk cycles; legal ≥2.
- CS_GAP, 2: minimum idle clk cycles with CS_N high between frames; legal ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  block accepts tx_data this cycle.
- rx_data  out  DATA_W  last received word; held until next rx_valid.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- busy  out  1  high from accept until end of GAP.
- sclk  out  1  SPI clock; idle low.
- mosi  out  1  serial data out.
- cs_n  out  1  chip select, active-low.
- miso  in  1  serial data in.

Behaviour:
- Reset values (rst_n=0 at posedge): sclk=0, cs_n=1, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0. State=IDLE, counters=0.
- Reset mid-frame aborts the frame. Next cycle has cs_n=1 and sclk=0. No rx_valid is issued and the partial word is discarded.
- All outputs are registered. tx_ready is registered-equivalent, with no combinational path from tx_valid.
- States: IDLE → SHIFT → HOLD → GAP → IDLE.
- IDLE: tx_ready=1, busy=0. On tx_valid&&tx_ready, latch tx_data into the shift register and go to SHIFT. The next cycle has cs_n=0, mosi=tx_data[DATA_W-1], sclk=0 and busy=1.
- SHIFT: each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
  - On the clk edge where sclk goes 0→1, miso is sampled into the rx shift register (LSB side, shifting left).
  - On the edge where sclk goes 1→0, mosi advances to the next bit.
  - After DATA_W bits, the frame takes exactly 2*DATA_W*CLK_DIV cycles from cs_n falling to the final sclk fall.
- End of word: on the cycle sclk falls for bit 0, rx_data takes the full received word and rx_valid=1 for one cycle.
- Burst: tx_ready=1 during the last sclk-high cycle of the final bit.
  - If tx_valid is high then, the new word is accepted and SHIFT restarts with cs_n held low.
  - mosi takes the new MSB on the same edge sclk falls, so there is no gap between words.
  - Otherwise the block enters HOLD.
- HOLD: cs_n low, sclk low for CLK_DIV cycles, then cs_n=1 and the block enters GAP.
- GAP: cs_n=1, tx_ready=0, busy=1 for CS_GAP cycles, then IDLE. The minimum cs_n-high time between frames is therefore CS_GAP+1 cycles.
- tx_valid outside a tx_ready cycle is ignored. tx_data must be held by the producer until accepted.
- In IDLE, HOLD and GAP, mosi holds the last driven value. It is 0 after reset.
- miso is used unsynchronised. Timing is met by the mode-0 half-period (CLK_DIV≥2).

Decomposition:
- spi_pkg: state enum (IDLE, SHIFT, HOLD, GAP), SPI mode constants (CPOL=0, CPHA=0), bit-counter width function $clog2(DATA_W+1).
- Sub-module spi_clk_gen: half-period counter producing one-cycle rise_tick/fall_tick strobes and the sclk level. It is enabled only in SHIFT and cleared on entry.
- The top module holds the FSM, shift registers, bit counter and gap counter.

Test Plan:
- Defaults, miso looped to mosi, send 0xA5 → mosi sequence 1,0,1,0,0,1,0,1 at sclk rises; 8 sclk pulses; cs_n low for 64+4 cycles; rx_valid pulse with rx_data=0xA5.
- miso tied 1, send 0x00 → rx_data=0xFF, mosi=0 throughout; then miso tied 0, send 0xFF → rx_data=0x00.
- Burst 0x3C,0xC3 with tx_valid held → cs_n low continuously across 16 sclk pulses; two rx_valid pulses exactly 64 cycles apart; no sclk gap.
- Two separate frames with tx_valid asserted immediately after GAP → cs_n high for exactly CS_GAP+1=3 cycles between frames; tx_ready=0 during GAP.
- Assert rst_n=0 for 1 cycle after the 3rd sclk rise → next cycle cs_n=1 and sclk=0; no rx_valid; the following 0x5A frame completes correctly.
- tx_valid pulsed mid-SHIFT with 0x11 while the frame is not on its final bit → ignored; only the original word is transmitted.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 transmit master.
// Imported by the clock generator and the top-level controller.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period down-counter with one-cycle edge strobes.
// Strobes mark the clk edge on which sclk changes level.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o,
  output logic pre_fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          terminal;

  assign terminal    = (cnt_q == '0);
  assign rise_tick_o = en_i && !sclk_q && terminal;
  assign fall_tick_o = en_i && sclk_q && terminal;
  // Asserted one cycle before the falling strobe, i.e. entering the last high cycle.
  assign pre_fall_o  = en_i && sclk_q && (cnt_q == CW'(1));
  assign sclk_o      = sclk_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      sclk_q <= SPI_CPOL;
    end else if (clr_i) begin
      cnt_q  <= CW'(CLK_DIV - 1);
      sclk_q <= SPI_CPOL;
    end else if (en_i) begin
      if (terminal) begin
        cnt_q  <= CW'(CLK_DIV - 1);
        sclk_q <= ~sclk_q;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: serialises words MSB-first, captures MISO, and
// chains back-to-back words under a single chip-select assertion.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              cs_n_o,
  input  logic              miso_i
);

  localparam int BW   = bit_cnt_w(DATA_W);
  localparam int TMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  spi_state_e        state_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              tx_ready_q;
  logic              busy_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic [BW-1:0]     bit_q;
  logic [TW-1:0]     tmr_q;

  logic rise_tick, fall_tick, pre_fall, sample_tick;
  logic accept, last_bit;

  // tx_ready_q is only ever high in IDLE or the final high cycle of a word.
  assign accept      = tx_valid_i && tx_ready_q;
  assign last_bit    = (bit_q == BW'(DATA_W - 1));
  assign sample_tick = (SPI_CPHA == 1'b0) ? rise_tick : fall_tick;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (state_q == ST_SHIFT),
    .clr_i       (accept),
    .sclk_o      (sclk_o),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick),
    .pre_fall_o  (pre_fall)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      bit_q      <= '0;
      tmr_q      <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          cs_n_q     <= 1'b1;
          if (accept) begin
            tx_sr_q    <= tx_data_i;
            mosi_q     <= tx_data_i[DATA_W-1];
            bit_q      <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cs_n_q     <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          tx_ready_q <= pre_fall && last_bit;
          if (sample_tick) rx_sr_q <= {rx_sr_q[DATA_W-2:0], miso_i};
          if (fall_tick) begin
            if (last_bit) begin
              rx_data_q  <= rx_sr_q;
              rx_valid_q <= 1'b1;
              bit_q      <= '0;
              if (accept) begin
                tx_sr_q <= tx_data_i;
                mosi_q  <= tx_data_i[DATA_W-1];
              end else begin
                tmr_q   <= TW'(CLK_DIV - 1);
                state_q <= ST_HOLD;
              end
            end else begin
              bit_q   <= bit_q + BW'(1);
              tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
              mosi_q  <= tx_sr_q[DATA_W-2];
            end
          end
        end
        ST_HOLD: begin
          if (tmr_q == '0) begin
            cs_n_q  <= 1'b1;
            tmr_q   <= TW'(CS_GAP - 1);
            state_q <= ST_GAP;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        ST_GAP: begin
          if (tmr_q == '0) begin
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;

endmodule
